// File: rtl/counter_pkg.sv
// Shared types for the programmable up/down counter: boundary modes and FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/count_step_calc.sv
// Combinational step evaluation: given the current count, step, range and mode,
// produce the count after one step, the terminal-count flag and a limit-hit flag.
module count_step_calc
  import counter_pkg::*;
#(
  parameter int NBITS_COUNT = 8
) (
  input  logic [NBITS_COUNT-1:0] count,
  input  logic [NBITS_COUNT-1:0] step,
  input  logic [NBITS_COUNT-1:0] min_val,
  input  logic [NBITS_COUNT-1:0] max_val,
  input  logic                   count_up,
  input  logic [1:0]             mode,
  output logic [NBITS_COUNT-1:0] count_next,
  output logic                   tc_next,
  output logic                   hit_limit
);

  localparam int W = NBITS_COUNT + 1;

  logic [W-1:0]           count_w;
  logic [W-1:0]           step_w;
  logic [W-1:0]           min_w;
  logic [W-1:0]           max_w;
  logic [W-1:0]           nxt_w;
  logic [NBITS_COUNT-1:0] limit;
  logic [NBITS_COUNT-1:0] wrap_val;
  logic                   out_of_range;
  logic                   exact;
  mode_t                  mode_q;

  // One extra bit so a carry past all-ones is seen as overflow rather than lost.
  assign count_w = {1'b0, count};
  assign step_w  = {1'b0, step};
  assign min_w   = {1'b0, min_val};
  assign max_w   = {1'b0, max_val};
  assign mode_q  = mode_t'(mode);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    nxt_w        = '0;
    limit        = '0;
    wrap_val     = '0;
    out_of_range = 1'b0;
    count_next   = count;
    tc_next      = 1'b0;

    if (count_up) begin
      nxt_w        = count_w + step_w;
      out_of_range = (nxt_w > max_w);
      limit        = max_val;
      wrap_val     = min_val;
    end else begin
      nxt_w        = count_w - step_w;
      out_of_range = (count_w < (min_w + step_w));
      limit        = min_val;
      wrap_val     = max_val;
    end

    // Without a boundary crossing nxt_w is known to fit in NBITS_COUNT bits.
    exact = !out_of_range && (nxt_w[NBITS_COUNT-1:0] == limit);

    if (!out_of_range) begin
      count_next = nxt_w[NBITS_COUNT-1:0];
      tc_next    = exact;
    end else begin
      unique case (mode_q)
        MODE_SAT: begin
          count_next = limit;
          tc_next    = (count != limit);
        end
        MODE_ONESHOT: begin
          count_next = limit;
          tc_next    = 1'b1;
        end
        default: begin
          count_next = wrap_val;
          tc_next    = 1'b1;
        end
      endcase
    end
  end

  assign hit_limit = out_of_range || exact;

endmodule

// File: rtl/counter_up_down_prog.sv
// Programmable up/down counter with [min_val,max_val] range, step size and
// wrap / saturate / one-shot boundary handling; holds the registers and the FSM.
module counter_up_down_prog
  import counter_pkg::*;
#(
  parameter int NBITS_COUNT = 8,
  parameter int RESET_VAL   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [NBITS_COUNT-1:0] data_in,
  input  logic                   count_on,
  input  logic                   count_up,
  input  logic [NBITS_COUNT-1:0] step,
  input  logic [NBITS_COUNT-1:0] min_val,
  input  logic [NBITS_COUNT-1:0] max_val,
  input  logic [1:0]             mode,
  output logic [NBITS_COUNT-1:0] count,
  output logic                   tc,
  output logic                   done,
  output logic                   err
);

  cnt_state_t             state;
  mode_t                  mode_q;
  logic [NBITS_COUNT-1:0] count_next;
  logic                   tc_next;
  logic                   hit_limit;
  logic                   step_en;

  assign mode_q = mode_t'(mode);

  count_step_calc #(
    .NBITS_COUNT(NBITS_COUNT)
  ) u_step_calc (
    .count     (count),
    .step      (step),
    .min_val   (min_val),
    .max_val   (max_val),
    .count_up  (count_up),
    .mode      (mode),
    .count_next(count_next),
    .tc_next   (tc_next),
    .hit_limit (hit_limit)
  );

  // A zero step is treated as "no step" so it can never raise tc.
  assign step_en = count_on && !err && (state != ST_DONE) && (step != '0);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      count <= NBITS_COUNT'(RESET_VAL);
      tc    <= 1'b0;
      err   <= 1'b0;
      state <= ST_IDLE;
    end else begin
      err <= (min_val > max_val);
      if (load) begin
        count <= data_in;
        tc    <= 1'b0;
        state <= ST_RUN;
      end else if (step_en) begin
        count <= count_next;
        tc    <= tc_next;
        if ((mode_q == MODE_ONESHOT) && hit_limit) begin
          state <= ST_DONE;
        end
      end else begin
        tc <= 1'b0;
        if ((state == ST_DONE) && (mode_q != MODE_ONESHOT)) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign done = (state == ST_DONE);

endmodule
